// File: rtl/unidade_busca.sv
// Fetch sequencer: owns the PC, latches instructions into ir, waits for exec_done, then steps or branches; stops on HALT_OPCODE.
// Two cycles minimum per instruction (FETCH+EXEC); datapath stalls by holding exec_done low. Optional macro: FIM_MEMORIA_HALT_EN.
module unidade_busca #(
  parameter int                    ADDR_W      = 8,
  parameter int                    INSTR_W     = 8,
  parameter int                    OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0]   HALT_OPCODE = 4'b1111,
  parameter int                    CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valido,
  input  logic               exec_done,
  input  logic               desvio_en,
  input  logic [ADDR_W-1:0]  desvio_alvo,
  output logic               halted,
  output logic               erro_fim,
  output logic [CNT_W-1:0]   contagem_instr
);

`ifdef FIM_MEMORIA_HALT_EN
  localparam bit FIM_HALT = 1'b1;
`else
  localparam bit FIM_HALT = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PC_ULTIMO = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} estado_t;

  estado_t              state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 ir_valido_q, ir_valido_d;
  logic                 halted_q, halted_d;
  logic                 erro_fim_q, erro_fim_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [OPCODE_W-1:0]  opcode;
  logic [CNT_W-1:0]     cnt_sat;

  assign opcode  = instrucao[INSTR_W-1 -: OPCODE_W];
  assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valido_d = 1'b0;
    halted_d    = halted_q;
    erro_fim_d  = erro_fim_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ir_d = instrucao;
        if (opcode == HALT_OPCODE) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          state_d     = EXEC;
          ir_valido_d = 1'b1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          cnt_d   = cnt_sat;
          state_d = FETCH;
          if (desvio_en) begin
            pc_d = desvio_alvo;
          end else if (FIM_HALT && (pc_q == PC_ULTIMO)) begin
            // Running off the end of memory stops instead of wrapping; PC stays on the last address.
            state_d    = HALT;
            halted_d   = 1'b1;
            erro_fim_d = 1'b1;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          pc_d       = '0;
          halted_d   = 1'b0;
          erro_fim_d = 1'b0;
          cnt_d      = '0;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ir_valido_q <= 1'b0;
      halted_q    <= 1'b0;
      erro_fim_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valido_q <= ir_valido_d;
      halted_q    <= halted_d;
      erro_fim_q  <= erro_fim_d;
      cnt_q       <= cnt_d;
    end
  end

  assign endereco       = pc_q;
  assign ir             = ir_q;
  assign ir_valido      = ir_valido_q;
  assign halted         = halted_q;
  assign erro_fim       = erro_fim_q;
  assign contagem_instr = cnt_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed table of steps/branches, halt and reset sequences, random program walk vs. a PC/count model.
module tb_unidade_busca;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  endereco;
  logic [7:0]  instrucao;
  logic [7:0]  ir;
  logic        ir_valido;
  logic        exec_done;
  logic        desvio_en;
  logic [7:0]  desvio_alvo;
  logic        halted;
  logic        erro_fim;
  logic [15:0] contagem_instr;

  logic [7:0]  mem [256];
  int          checks;
  int          failures;

  assign instrucao = mem[endereco];

  unidade_busca dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .endereco       (endereco),
    .instrucao      (instrucao),
    .ir             (ir),
    .ir_valido      (ir_valido),
    .exec_done      (exec_done),
    .desvio_en      (desvio_en),
    .desvio_alvo    (desvio_alvo),
    .halted         (halted),
    .erro_fim       (erro_fim),
    .contagem_instr (contagem_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       den;
    logic [7:0] alvo;
    int         stall;
    logic [7:0] exp_pc;
  } passo_t;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ir_valido) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_ir_valido: got no pulse expected pulse within 12 cycles");
    end
  endtask

  // Stall with garbage branch inputs (must be ignored), then complete the instruction.
  task automatic executa(input logic den, input logic [7:0] alvo, input int stall);
    logic [7:0] pc0, ir0;
    pc0 = endereco;
    ir0 = ir;
    exec_done = 1'b0;
    for (int i = 0; i < stall; i++) begin
      desvio_en   = 1'b1;
      desvio_alvo = 8'($urandom);
      tick();
      chk("stall_ir_valido", ir_valido, 0);
      chk("stall_endereco", endereco, pc0);
      chk("stall_ir", ir, ir0);
    end
    exec_done   = 1'b1;
    desvio_en   = den;
    desvio_alvo = alvo;
    tick();
    exec_done   = 1'b0;
    desvio_en   = 1'b0;
    desvio_alvo = 8'h00;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #20 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    passo_t     tab [6];
    logic [7:0] exp_ir [3];
    logic [7:0] exp_pc;
    logic [15:0] exp_cnt;
    logic [7:0] v;
    int         npulse, last;
    logic       den;
    logic [7:0] alvo;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    exec_done = 1'b0;
    desvio_en = 1'b0;
    desvio_alvo = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    tab[0] = '{den: 1'b0, alvo: 8'h00, stall: 0, exp_pc: 8'h01};
    tab[1] = '{den: 1'b1, alvo: 8'h10, stall: 0, exp_pc: 8'h10};
    tab[2] = '{den: 1'b0, alvo: 8'h00, stall: 5, exp_pc: 8'h11};
    tab[3] = '{den: 1'b1, alvo: 8'h11, stall: 2, exp_pc: 8'h11};
    tab[4] = '{den: 1'b1, alvo: 8'hFE, stall: 0, exp_pc: 8'hFE};
    tab[5] = '{den: 1'b0, alvo: 8'h00, stall: 1, exp_pc: 8'hFF};

    // Reset and idle with start low
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_endereco", endereco, 0);
      chk("idle_ir_valido", ir_valido, 0);
      chk("idle_halted", halted, 0);
      chk("idle_contagem", contagem_instr, 0);
    end
    chk("idle_erro_fim", erro_fim, 0);
    chk("idle_ir", ir, 0);

    // Straight-line program ending in halt, exec_done held high
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'hF0;
    exp_ir[0] = 8'h12; exp_ir[1] = 8'h34; exp_ir[2] = 8'h56;
    exec_done = 1'b1;
    pulse_start();
    chk("seq_first_endereco", endereco, 0);
    npulse = 0;
    last = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (ir_valido) begin
        if (npulse < 3) begin
          chk("seq_endereco", endereco, npulse);
          chk("seq_ir", ir, exp_ir[npulse]);
          if (npulse > 0) chk("seq_gap", c - last, 2);
        end
        last = c;
        npulse++;
      end
    end
    exec_done = 1'b0;
    chk("seq_npulses", npulse, 3);
    chk("seq_halted", halted, 1);
    chk("seq_contagem", contagem_instr, 3);
    chk("seq_endereco_halt", endereco, 3);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halt_frozen_endereco", endereco, 3);
      chk("halt_no_valid", ir_valido, 0);
    end

    // Restart from HALT, then directed step/branch/stall table
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 5 + 1) & 8'h7F);
    mem[255] = 8'h00;
    pulse_start();
    chk("restart_halted", halted, 0);
    chk("restart_contagem", contagem_instr, 0);
    chk("restart_endereco", endereco, 0);
    chk("restart_erro_fim", erro_fim, 0);
    exp_pc = 8'h00;
    exp_cnt = 16'd0;
    for (int k = 0; k < 6; k++) begin
      wait_valid();
      chk("tab_endereco", endereco, exp_pc);
      chk("tab_ir", ir, mem[exp_pc]);
      chk("tab_contagem_before", contagem_instr, exp_cnt);
      executa(tab[k].den, tab[k].alvo, tab[k].stall);
      exp_cnt++;
      chk("tab_contagem_after", contagem_instr, exp_cnt);
      exp_pc = tab[k].exp_pc;
    end

    // Sequential advance from the last address
    wait_valid();
    chk("end_endereco", endereco, 8'hFF);
    chk("end_ir", ir, 8'h00);
    executa(1'b0, 8'h00, 0);
    exp_cnt++;
    chk("end_contagem", contagem_instr, exp_cnt);
`ifdef FIM_MEMORIA_HALT_EN
    chk("end_halted", halted, 1);
    chk("end_erro_fim", erro_fim, 1);
    chk("end_endereco_held", endereco, 8'hFF);
    tick();
    tick();
    chk("end_endereco_frozen", endereco, 8'hFF);
    chk("end_no_valid", ir_valido, 0);
`else
    chk("wrap_endereco", endereco, 8'h00);
    chk("wrap_erro_fim", erro_fim, 0);
    chk("wrap_halted", halted, 0);
    wait_valid();
    chk("wrap_fetch_endereco", endereco, 8'h00);
    chk("wrap_fetch_ir", ir, mem[0]);
`endif

    // Asynchronous reset in the middle of EXEC
    do_reset();
    pulse_start();
    wait_valid();
    executa(1'b0, 8'h00, 0);
    wait_valid();
    exec_done = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_endereco", endereco, 0);
    chk("arst_ir", ir, 0);
    chk("arst_ir_valido", ir_valido, 0);
    chk("arst_contagem", contagem_instr, 0);
    chk("arst_halted", halted, 0);
    chk("arst_erro_fim", erro_fim, 0);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_arst_no_valid", ir_valido, 0);
      chk("post_arst_endereco", endereco, 0);
    end
    pulse_start();
    wait_valid();
    chk("post_arst_fetch_endereco", endereco, 0);
    chk("post_arst_fetch_ir", ir, mem[0]);

    // Random program walk against a PC/count model, finishing at a halt word
    do_reset();
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (v[7:4] == 4'hF) v[7] = 1'b0;
      mem[i] = v;
    end
    mem[8'hF0] = 8'hF5;
    pulse_start();
    exp_pc = 8'h00;
    exp_cnt = 16'd0;
    for (int n = 0; n < 80; n++) begin
      wait_valid();
      chk("rnd_endereco", endereco, exp_pc);
      chk("rnd_ir", ir, mem[exp_pc]);
      chk("rnd_contagem", contagem_instr, exp_cnt);
      den  = ($urandom_range(0, 3) == 0) || (exp_pc >= 8'hD0);
      alvo = 8'($urandom_range(0, 8'hCF));
      executa(den, alvo, $urandom_range(0, 3));
      exp_cnt++;
      exp_pc = den ? alvo : exp_pc + 8'd1;
    end
    wait_valid();
    chk("rnd_last_endereco", endereco, exp_pc);
    executa(1'b1, 8'hF0, 0);
    exp_cnt++;
    for (int c = 0; c < 5 && !halted; c++) tick();
    chk("rnd_halted", halted, 1);
    chk("rnd_final_contagem", contagem_instr, exp_cnt);
    chk("rnd_final_endereco", endereco, 8'hF0);
    chk("rnd_final_ir", ir, 8'hF5);
    chk("rnd_final_no_valid", ir_valido, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
